// File: rtl/core.sv
// Shared definitions for the CPU MMIO timer: address type, register offsets,
// control-register layout, AXI response codes and a byte-lane merge helper.
package core;

  typedef logic [31:0] word_t;

  localparam word_t MMIO_BASE = 32'h4000_0000;

  typedef enum logic [4:0] {
    REG_MTIME_LO = 5'h00,
    REG_MTIME_HI = 5'h04,
    REG_CMP_LO   = 5'h08,
    REG_CMP_HI   = 5'h0C,
    REG_CTRL     = 5'h10,
    REG_PRESCALE = 5'h14
  } timer_reg_t;

  typedef struct packed {
    logic pend;
    logic ie;
    logic en;
  } ctrl_reg_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic word_t merge_bytes(word_t old_val, word_t new_val, logic [3:0] strb);
    word_t r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi.sv
// AXI4-Lite channel bundle, 32-bit data; master drives valids, slave drives readies.
interface axi;
  import core::*;

  word_t       awaddr;
  logic        awvalid;
  logic        awready;
  word_t       wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  word_t       araddr;
  logic        arvalid;
  logic        arready;
  word_t       rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_slave_if.sv
// AXI4-Lite responder FSMs flattened to a register strobe port. Write applies on the
// last AW/W handshake, B follows next cycle; read data registered 1 cycle after AR.
module axil_slave_if
  import core::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  axi.slave          bus,
  output logic       wr_en,
  output word_t      wr_addr,
  output word_t      wr_data,
  output logic [3:0] wr_strb,
  input  logic       wr_err,
  output logic       rd_en,
  output word_t      rd_addr,
  input  word_t      rd_data,
  input  logic       rd_err
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t    wstate_q, wstate_d;
  rstate_t    rstate_q, rstate_d;
  word_t      awaddr_q, awaddr_d;
  word_t      wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d;
  word_t      rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  always_comb begin
    wstate_d    = wstate_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    wr_en       = 1'b0;
    wr_addr     = awaddr_q;
    wr_data     = wdata_q;
    wr_strb     = wstrb_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        // Readies are held low while reset is asserted.
        bus.awready = aresetn;
        bus.wready  = aresetn;
        if (bus.awvalid && bus.wvalid) begin
          wr_en     = 1'b1;
          wr_addr   = bus.awaddr;
          wr_data   = bus.wdata;
          wr_strb   = bus.wstrb;
          wstate_d  = W_RESP;
        end else if (bus.awvalid) begin
          awaddr_d  = bus.awaddr;
          wstate_d  = W_ADDR;
        end else if (bus.wvalid) begin
          wdata_d   = bus.wdata;
          wstrb_d   = bus.wstrb;
          wstate_d  = W_DATA;
        end
      end
      W_ADDR: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          wr_en    = 1'b1;
          wr_data  = bus.wdata;
          wr_strb  = bus.wstrb;
          wstate_d = W_RESP;
        end
      end
      W_DATA: begin
        bus.awready = 1'b1;
        if (bus.awvalid) begin
          wr_en    = 1'b1;
          wr_addr  = bus.awaddr;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (wr_en) bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
  end

  assign bus.bvalid = (wstate_q == W_RESP);
  assign bus.bresp  = bresp_q;

  always_comb begin
    rstate_d    = rstate_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_en       = 1'b0;
    rd_addr     = bus.araddr;
    bus.arready = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        bus.arready = aresetn;
        if (bus.arvalid && aresetn) begin
          rd_en    = 1'b1;
          rdata_d  = rd_err ? '0 : rd_data;
          rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign bus.rvalid = (rstate_q == R_RESP);
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// 64-bit prescaled timer with compare interrupt behind an AXI4-Lite port.
// irq is registered one cycle behind the compare; bus backpressure lives in axil_slave_if.
module mmio_timer
  import core::*;
#(
  parameter int unsigned ADDR_BITS      = 5,
  parameter int unsigned PRESCALE_RESET = 0
) (
  input  logic aclk,
  input  logic aresetn,
  axi.slave    bus,
  output logic irq
);

  localparam word_t OFF_MASK = word_t'((64'd1 << ADDR_BITS) - 64'd1);
  localparam word_t LAST_OFF = 32'h14;

  function automatic logic addr_err(word_t a);
    word_t off;
    off = a & OFF_MASK;
    return (off[1:0] != 2'b00) || (off > LAST_OFF);
  endfunction

  logic        wr_en, wr_err, rd_en, rd_err;
  word_t       wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_strb;

  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic        en_q, en_d, ie_q, ie_d, irq_q;
  logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic        pend, tick, wr_ok;
  ctrl_reg_t   ctrl_rd;

  axil_slave_if u_axil (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  assign wr_err  = addr_err(wr_addr);
  assign rd_err  = addr_err(rd_addr);
  assign pend    = (mtime_q >= cmp_q);
  assign ctrl_rd = '{pend: pend, ie: ie_q, en: en_q};
  assign irq     = irq_q;
  // >= rather than == so lowering PRESCALE below the running count cannot stall the timer.
  assign tick    = en_q && (pcnt_q >= prescale_q);
  assign wr_ok   = wr_en && !wr_err && (wr_strb != 4'd0);

  always_comb begin
    rd_data = '0;
    if (rd_en && !rd_err) begin
      case (timer_reg_t'(rd_addr[4:0]))
        REG_MTIME_LO: rd_data = mtime_q[31:0];
        REG_MTIME_HI: rd_data = mtime_q[63:32];
        REG_CMP_LO:   rd_data = cmp_q[31:0];
        REG_CMP_HI:   rd_data = cmp_q[63:32];
        REG_CTRL:     rd_data = {29'd0, ctrl_rd};
        REG_PRESCALE: rd_data = {16'd0, prescale_q};
        default:      rd_data = '0;
      endcase
    end
  end

  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    pcnt_d     = tick ? 16'd0 : (en_q ? pcnt_q + 16'd1 : pcnt_q);
    cmp_d      = cmp_q;
    en_d       = en_q;
    ie_d       = ie_q;
    prescale_d = prescale_q;
    if (wr_ok) begin
      // An mtime write starts from the un-incremented value, so that cycle's tick is lost.
      case (timer_reg_t'(wr_addr[4:0]))
        REG_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wr_data, wr_strb)};
          pcnt_d  = 16'd0;
        end
        REG_MTIME_HI: begin
          mtime_d = {merge_bytes(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
          pcnt_d  = 16'd0;
        end
        REG_CMP_LO: cmp_d = {cmp_q[63:32], merge_bytes(cmp_q[31:0], wr_data, wr_strb)};
        REG_CMP_HI: cmp_d = {merge_bytes(cmp_q[63:32], wr_data, wr_strb), cmp_q[31:0]};
        REG_CTRL: begin
          if (wr_strb[0]) begin
            en_d = wr_data[0];
            ie_d = wr_data[1];
          end
        end
        REG_PRESCALE: begin
          if (wr_strb[0]) prescale_d[7:0]  = wr_data[7:0];
          if (wr_strb[1]) prescale_d[15:8] = wr_data[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mtime_q    <= '0;
      cmp_q      <= '1;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= 16'(PRESCALE_RESET);
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= pend & ie_q;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: vector table of register accesses, then
// hand-written sequences for counting, carry, irq timing and split handshakes.
module tb_mmio_timer;
  import core::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic irq;

  axi bus ();

  mmio_timer #(.ADDR_BITS(5), .PRESCALE_RESET(0)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 aclk = ~aclk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   irq_chg_cyc = 0;
  logic irq_prev = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (irq !== irq_prev) begin
      irq_prev = irq;
      irq_chg_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit         wr;
    word_t      off;
    word_t      data;
    logic [3:0] strb;
    logic [1:0] resp;
    word_t      rdata;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_wr(input word_t off, input word_t data, input logic [3:0] strb,
                        output logic [1:0] resp, output int hs_cyc);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got = 0;
    int n = 0;
    resp = 2'b11;
    hs_cyc = 0;
    @(posedge aclk); #1;
    bus.awaddr = MMIO_BASE + off; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge aclk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      n++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.wvalid = 1'b0;  w_done = 1;  end
      if (aw_done && w_done) hs_cyc = cyc;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge aclk);
      if (bus.bvalid) begin resp = bus.bresp; got = 1; end
      @(posedge aclk); #1;
      n++;
    end
    bus.bready = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wr_timeout: no B response for offset 0x%02h", off);
    end
  endtask

  task automatic axi_rd(input word_t off, output word_t data, output logic [1:0] resp);
    bit ar_hs, ar_done = 0, got = 0;
    int n = 0;
    data = 32'hDEAD_DEAD;
    resp = 2'b11;
    @(posedge aclk); #1;
    bus.araddr = MMIO_BASE + off; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!ar_done && n < 20) begin
      @(negedge aclk);
      ar_hs = bus.arvalid && bus.arready;
      @(posedge aclk); #1;
      n++;
      if (ar_hs) begin bus.arvalid = 1'b0; ar_done = 1; end
    end
    bus.arvalid = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge aclk);
      if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; got = 1; end
      @(posedge aclk); #1;
      n++;
    end
    bus.rready = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL rd_timeout: no R response for offset 0x%02h", off);
    end
  endtask

  task automatic wr(input word_t off, input word_t data);
    logic [1:0] r;
    int h;
    axi_wr(off, data, 4'hF, r, h);
    chk($sformatf("wr_resp_%02h", off), {30'd0, r}, {30'd0, RESP_OKAY});
  endtask

  task automatic rd_chk(input string name, input word_t off, input word_t exp);
    word_t d;
    logic [1:0] r;
    axi_rd(off, d, r);
    chk({name, "_resp"}, {30'd0, r}, {30'd0, RESP_OKAY});
    chk(name, d, exp);
  endtask

  // First handshake alone, three idle cycles, then the second; B held off for 5 cycles
  // while a stray AW+W is offered that must not be taken.
  task automatic split_wr(input bit aw_first, input word_t off, input word_t data, input string tag);
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    bus.awaddr = MMIO_BASE + off; bus.wdata = data; bus.wstrb = 4'hF;
    if (aw_first) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
    @(negedge aclk);
    chk({tag, "_first_rdy"}, {31'd0, aw_first ? bus.awready : bus.wready}, 32'd1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk({tag, "_wait_awready"}, {31'd0, bus.awready}, aw_first ? 32'd0 : 32'd1);
      chk({tag, "_wait_wready"},  {31'd0, bus.wready},  aw_first ? 32'd1 : 32'd0);
      chk({tag, "_wait_bvalid"},  {31'd0, bus.bvalid},  32'd0);
      @(posedge aclk); #1;
    end
    if (aw_first) bus.wvalid = 1'b1; else bus.awvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awaddr = MMIO_BASE + 32'h0C; bus.wdata = 32'h5555_5555;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      chk({tag, "_hold_bvalid"},  {31'd0, bus.bvalid},  32'd1);
      chk({tag, "_hold_bresp"},   {30'd0, bus.bresp},   {30'd0, RESP_OKAY});
      chk({tag, "_hold_awready"}, {31'd0, bus.awready}, 32'd0);
      chk({tag, "_hold_wready"},  {31'd0, bus.wready},  32'd0);
      @(posedge aclk); #1;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    @(negedge aclk);
    chk({tag, "_bvalid_drop"}, {31'd0, bus.bvalid}, 32'd0);
  endtask

  initial begin
    word_t      d;
    logic [1:0] r;
    int         h;
    int         n;

    vecs[0]  = '{0, 32'h08, 32'h0,          4'h0, RESP_OKAY,   32'hFFFF_FFFF};
    vecs[1]  = '{0, 32'h0C, 32'h0,          4'h0, RESP_OKAY,   32'hFFFF_FFFF};
    vecs[2]  = '{0, 32'h10, 32'h0,          4'h0, RESP_OKAY,   32'h0};
    vecs[3]  = '{0, 32'h14, 32'h0,          4'h0, RESP_OKAY,   32'h0};
    vecs[4]  = '{0, 32'h00, 32'h0,          4'h0, RESP_OKAY,   32'h0};
    vecs[5]  = '{0, 32'h04, 32'h0,          4'h0, RESP_OKAY,   32'h0};
    vecs[6]  = '{1, 32'h18, 32'h1111_1111,  4'hF, RESP_SLVERR, 32'h0};
    vecs[7]  = '{0, 32'h18, 32'h0,          4'h0, RESP_SLVERR, 32'h0};
    vecs[8]  = '{1, 32'h02, 32'h1234_5678,  4'hF, RESP_SLVERR, 32'h0};
    vecs[9]  = '{0, 32'h00, 32'h0,          4'h0, RESP_OKAY,   32'h0};
    vecs[10] = '{0, 32'h02, 32'h0,          4'h0, RESP_SLVERR, 32'h0};
    vecs[11] = '{1, 32'h08, 32'hAABB_CCDD,  4'h2, RESP_OKAY,   32'h0};
    vecs[12] = '{0, 32'h08, 32'h0,          4'h0, RESP_OKAY,   32'hFFFF_CCFF};
    vecs[13] = '{1, 32'h08, 32'h0,          4'h0, RESP_OKAY,   32'h0};
    vecs[14] = '{0, 32'h08, 32'h0,          4'h0, RESP_OKAY,   32'hFFFF_CCFF};
    vecs[15] = '{1, 32'h14, 32'hDEAD_1234,  4'hF, RESP_OKAY,   32'h0};
    vecs[16] = '{0, 32'h14, 32'h0,          4'h0, RESP_OKAY,   32'h0000_1234};
    vecs[17] = '{1, 32'h14, 32'h0000_5600,  4'h2, RESP_OKAY,   32'h0};
    vecs[18] = '{0, 32'h14, 32'h0,          4'h0, RESP_OKAY,   32'h0000_5634};
    vecs[19] = '{1, 32'h10, 32'hFFFF_FFFC,  4'hF, RESP_OKAY,   32'h0};
    vecs[20] = '{1, 32'h0C, 32'h0,          4'hF, RESP_OKAY,   32'h0};
    vecs[21] = '{1, 32'h04, 32'h1,          4'hF, RESP_OKAY,   32'h0};
    vecs[22] = '{0, 32'h10, 32'h0,          4'h0, RESP_OKAY,   32'h4};
    vecs[23] = '{0, 32'h28, 32'h0,          4'h0, RESP_OKAY,   32'hFFFF_CCFF};

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", {31'd0, bus.awready}, 32'd0);
    chk("rst_wready",  {31'd0, bus.wready},  32'd0);
    chk("rst_arready", {31'd0, bus.arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bus.bresp},   32'd0);
    chk("rst_rresp",   {30'd0, bus.rresp},   32'd0);
    chk("rst_rdata",   bus.rdata,            32'd0);
    chk("rst_irq",     {31'd0, irq},         32'd0);
    aresetn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) begin
        axi_wr(vecs[i].off, vecs[i].data, vecs[i].strb, r, h);
        chk($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].resp});
      end else begin
        axi_rd(vecs[i].off, d, r);
        chk($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].resp});
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      end
    end
    @(negedge aclk);
    chk("irq_masked_by_ie", {31'd0, irq}, 32'd0);

    // Prescaled counting: PRESCALE=3 gives one tick per 4 cycles.
    wr(32'h14, 32'd3);
    wr(32'h00, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h10, 32'h1);
    repeat (40) @(posedge aclk);
    axi_rd(32'h00, d, r);
    checks++;
    if (!(d == 32'd9 || d == 32'd10)) begin
      errors++;
      $display("FAIL prescale_mtime_lo: got %0d expected 9 or 10", d);
    end
    rd_chk("prescale_mtime_hi", 32'h04, 32'd0);

    // Carry from the low half into the high half.
    wr(32'h10, 32'h0);
    wr(32'h14, 32'h0);
    wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h04, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h10, 32'h0);
    rd_chk("carry_mtime_hi", 32'h04, 32'd1);
    rd_chk("carry_mtime_lo", 32'h00, 32'd1);

    // Compare interrupt rise and fall timing.
    wr(32'h00, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd20);
    @(negedge aclk);
    chk("irq_before_enable", {31'd0, irq}, 32'd0);
    axi_wr(32'h10, 32'h3, 4'hF, r, h);
    n = 0;
    while (irq !== 1'b1 && n < 60) begin
      @(negedge aclk);
      n++;
    end
    #1;
    chk("irq_rise", {31'd0, irq}, 32'd1);
    chk("irq_rise_latency", irq_chg_cyc - h, 32'd21);
    rd_chk("ctrl_pend_ie_en", 32'h10, 32'h7);
    axi_wr(32'h08, 32'd100, 4'hF, r, h);
    repeat (3) @(negedge aclk);
    #1;
    chk("irq_fall", {31'd0, irq}, 32'd0);
    chk("irq_fall_latency", irq_chg_cyc - h, 32'd1);
    wr(32'h10, 32'h0);

    // Split AW/W handshakes with B backpressure.
    split_wr(1'b1, 32'h08, 32'h1234_5678, "aw_first");
    rd_chk("aw_first_cmp_lo", 32'h08, 32'h1234_5678);
    rd_chk("aw_first_cmp_hi", 32'h0C, 32'h0);
    split_wr(1'b0, 32'h08, 32'h8765_4321, "w_first");
    rd_chk("w_first_cmp_lo", 32'h08, 32'h8765_4321);
    rd_chk("w_first_cmp_hi", 32'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
